serial_addsub_digit: RTL and testbench
======================================

Name: serial_addsub_digit

Overview:
Parametrised digit-serial add/subtract unit, the successor to the 32-bit bit-serial adder's controller and datapath. It processes D bits per clock over W/D cycles and supports add and subtract modes. It produces carry/borrow and signed-overflow flags and uses a start/done return-to-zero handshake with synchronous abort. It sits between a register-mapped operand source and a result consumer.

Parameters:
W, 32, operand/result width in bits; must be a multiple of D.
D, 1, digit width (bits processed per ADD cycle); legal values are 1, 2, 4, 8.
NDIG, W/D (derived localparam), number of ADD cycles; counter width is clog2(NDIG), minimum 1.

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  request level; held high until done is seen, then dropped
mode  in  1  0 = add (a+b), 1 = subtract (a-b); sampled in LOAD
clear  in  1  synchronous abort, highest priority after rst
a  in  W  operand A; stable from start-high through the LOAD cycle
b  in  W  operand B; same stability rule as a
busy  out  1  high in LOAD and ADD
done  out  1  high in DONE only
sum  out  W  result; valid while done=1, held in IDLE until next LOAD
carry_out  out  1  add: carry out of MSB; sub: 1 = no borrow (a>=b unsigned)
overflow  out  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Reset (rst=1, asynchronous): state=IDLE; counter, carry flop, shift registers, sum, carry_out and overflow all 0; busy=0; done=0.
- FSM states (2-bit): IDLE, LOAD, ADD, DONE.
- IDLE: go to LOAD when start=1, otherwise stay.
- LOAD: single cycle, then ADD unconditionally.
  - At the LOAD edge, capture a into A_sh.
  - Capture b (mode=0) or ~b (mode=1) into B_sh.
  - Set carry flop = mode. Clear the counter, sum, carry_out and overflow.
- ADD: one digit per cycle, LSB digit first.
  - Compute the D-bit sum of A_sh[D-1:0] + B_sh[D-1:0] + carry.
  - Shift A_sh and B_sh right by D. Shift the digit sum into sum from the MSB end, right-shifting sum.
  - Update the carry flop and increment the counter.
  - On the last digit (counter == NDIG-1):
    - carry_out <= digit carry out.
    - overflow <= carry into bit D-1 of that digit XOR carry out.
    - Go to DONE.
- DONE: done=1. Go to IDLE when start=0, otherwise hold in DONE, so start held high never retriggers.
- Latency: with start sampled high at edge 0, LOAD follows edge 0, ADD covers edges 1..NDIG, and done is high after edge NDIG+1.
  - Defaults (D=1): done at edge 33.
  - W=32, D=4: done at edge 9.
- Operand or mode changes during ADD/DONE have no effect.
- clear=1 (synchronous, any state): next state IDLE; counter and carry cleared; sum, carry_out and overflow cleared; clear overrides start in the same cycle.
- rst asserted mid-ADD: immediate return to IDLE with all reset values; no partial result is retained.
- Subtract arithmetic is a + ~b + 1. Result wraps modulo 2^W. Flags follow the definitions in Ports.

Decomposition:
- Shared package serial_arith_pkg holds:
  - the state encoding constants (IDLE=2'b00, LOAD=2'b01, ADD=2'b10, DONE=2'b11);
  - MODE_ADD/MODE_SUB constants;
  - a clog2 function.
- One natural sub-module, serial_digit_adder: combinational, D-bit inputs a_d, b_d, cin; outputs s_d, cout, c_msb_in (carry into bit D-1).
- The FSM, counter and shift registers stay in the top level.

Test Plan:
- W=32, D=1, add 0xFFFFFFFF + 0x00000001 -> sum=0x00000000, carry_out=1, overflow=0, done first high after edge 33, busy high for exactly 33 cycles.
- W=32, D=1, sub 5 - 7 -> sum=0xFFFFFFFE, carry_out=0 (borrow), overflow=0; then sub 7 - 5 -> sum=2, carry_out=1.
- W=32, D=4, add 0x7FFFFFFF + 0x00000001 -> sum=0x80000000, overflow=1, carry_out=0, done after edge 9; sub 0x80000000 - 1 -> sum=0x7FFFFFFF, overflow=1.
- Handshake: keep start high 10 cycles past done -> state stays DONE and sum is stable; drop start -> IDLE next edge; reassert start -> new LOAD with freshly sampled operands.
- Assert rst for 1 cycle at ADD cycle 12 (D=1) -> busy/done/sum/flags all 0 immediately; next start gives a correct full result.
- Assert clear together with start in IDLE -> stays IDLE. Assert clear mid-ADD -> IDLE next edge, sum=0, no done pulse.

Source files
------------

// File: rtl/serial_arith_pkg.sv
// Shared constants and helpers for the digit-serial add/subtract unit.
// Holds FSM state encodings, mode encodings and a clog2 helper.
package serial_arith_pkg;

   localparam logic [1:0] ST_IDLE = 2'b00;
   localparam logic [1:0] ST_LOAD = 2'b01;
   localparam logic [1:0] ST_ADD  = 2'b10;
   localparam logic [1:0] ST_DONE = 2'b11;

   localparam logic MODE_ADD = 1'b0;
   localparam logic MODE_SUB = 1'b1;

   function automatic int clog2(input int v);
      int r;
      r = 0;
      while ((1 << r) < v)
         r++;
      return r;
   endfunction

endpackage

// File: rtl/serial_digit_adder.sv
// Combinational D-bit ripple adder for one digit of the serial datapath.
// Ports: a_d, b_d, cin in; s_d sum, cout carry out, c_msb_in carry into bit D-1.
module serial_digit_adder #(
   parameter int D = 1
) (
   input  logic [D-1:0] a_d,
   input  logic [D-1:0] b_d,
   input  logic         cin,
   output logic [D-1:0] s_d,
   output logic         cout,
   output logic         c_msb_in
);

   logic c;

   always_comb begin
      c        = cin;
      s_d      = '0;
      c_msb_in = cin;
      for (int i = 0; i < D; i++) begin
         if (i == D - 1)
            c_msb_in = c;
         s_d[i] = a_d[i] ^ b_d[i] ^ c;
         c      = (a_d[i] & b_d[i]) | (c & (a_d[i] ^ b_d[i]));
      end
      cout = c;
   end

endmodule

// File: rtl/serial_addsub_digit.sv
// Digit-serial add/subtract: D bits per cycle over W/D cycles, start/done handshake.
// Ports: clk, rst, start, mode, clear, a, b in; busy, done, sum, carry_out, overflow out.
module serial_addsub_digit
   import serial_arith_pkg::*;
#(
   parameter int W = 32,
   parameter int D = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic         mode,
   input  logic         clear,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] sum,
   output logic         carry_out,
   output logic         overflow
);

   localparam int NDIG = W / D;
   localparam int CW   = (clog2(NDIG) < 1) ? 1 : clog2(NDIG);

   logic [1:0]    state;
   logic [1:0]    nxt;
   logic [CW-1:0] cnt;
   logic          cy;
   logic [W-1:0]  a_sh;
   logic [W-1:0]  b_sh;
   logic [W-1:0]  sum_nxt;
   logic [D-1:0]  s_d;
   logic          cout;
   logic          c_msb_in;
   logic          last;

   assign last = (cnt == CW'(NDIG - 1));

   serial_digit_adder #(.D(D)) u_dig (
      .a_d      (a_sh[D-1:0]),
      .b_d      (b_sh[D-1:0]),
      .cin      (cy),
      .s_d      (s_d),
      .cout     (cout),
      .c_msb_in (c_msb_in)
   );

   // New digit enters at the MSB end; after NDIG shifts the LSB digit
   // has travelled down to bit 0.
   always_comb begin
      sum_nxt            = sum >> D;
      sum_nxt[W-1 -: D]  = s_d;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state <= ST_IDLE;
      else
         state <= nxt;
   end

   always_comb begin
      nxt = state;
      if (clear) begin
         nxt = ST_IDLE;
      end else begin
         unique case (state)
            ST_IDLE: if (start) nxt = ST_LOAD;
            ST_LOAD: nxt = ST_ADD;
            ST_ADD:  if (last) nxt = ST_DONE;
            ST_DONE: if (!start) nxt = ST_IDLE;
            default: nxt = ST_IDLE;
         endcase
      end
   end

   always_comb begin
      busy = (state == ST_LOAD) || (state == ST_ADD);
      done = (state == ST_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt       <= '0;
         cy        <= 1'b0;
         a_sh      <= '0;
         b_sh      <= '0;
         sum       <= '0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
      end else if (clear) begin
         cnt       <= '0;
         cy        <= 1'b0;
         sum       <= '0;
         carry_out <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         case (state)
            ST_LOAD: begin
               a_sh      <= a;
               // Subtract as a + ~b + 1: the +1 rides in on the carry.
               b_sh      <= (mode == MODE_SUB) ? ~b : b;
               cy        <= mode;
               cnt       <= '0;
               sum       <= '0;
               carry_out <= 1'b0;
               overflow  <= 1'b0;
            end
            ST_ADD: begin
               a_sh <= a_sh >> D;
               b_sh <= b_sh >> D;
               sum  <= sum_nxt;
               cy   <= cout;
               cnt  <= cnt + 1'b1;
               if (last) begin
                  carry_out <= cout;
                  overflow  <= c_msb_in ^ cout;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_serial_addsub_digit.sv
// Directed self-checking bench for serial_addsub_digit.
// Two instances: W=32 D=1 and W=32 D=4, sharing clk and rst.
module tb_serial_addsub_digit;

   logic        clk = 1'b0;
   logic        rst;

   logic        s1, m1, c1;
   logic [31:0] a1, b1;
   logic        busy1, done1, co1, ov1;
   logic [31:0] sum1;

   logic        s4, m4, c4;
   logic [31:0] a4, b4;
   logic        busy4, done4, co4, ov4;
   logic [31:0] sum4;

   int vecs = 0;
   int errs = 0;

   always #5 clk = ~clk;

   serial_addsub_digit #(.W(32), .D(1)) dut1 (
      .clk       (clk),
      .rst       (rst),
      .start     (s1),
      .mode      (m1),
      .clear     (c1),
      .a         (a1),
      .b         (b1),
      .busy      (busy1),
      .done      (done1),
      .sum       (sum1),
      .carry_out (co1),
      .overflow  (ov1)
   );

   serial_addsub_digit #(.W(32), .D(4)) dut4 (
      .clk       (clk),
      .rst       (rst),
      .start     (s4),
      .mode      (m4),
      .clear     (c4),
      .a         (a4),
      .b         (b4),
      .busy      (busy4),
      .done      (done4),
      .sum       (sum4),
      .carry_out (co4),
      .overflow  (ov4)
   );

   // Raise start, count edges (edge 0 = first sampling edge) until done.
   task automatic go1(input logic [31:0] a, input logic [31:0] b,
                      input logic m, output logic ok,
                      output int n, output int bc);
      @(negedge clk);
      a1 = a; b1 = b; m1 = m; s1 = 1'b1;
      n = -1; bc = 0; ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         n++;
         if (busy1) bc++;
         if (done1) begin ok = 1'b1; break; end
      end
   endtask

   task automatic go4(input logic [31:0] a, input logic [31:0] b,
                      input logic m, output logic ok,
                      output int n, output int bc);
      @(negedge clk);
      a4 = a; b4 = b; m4 = m; s4 = 1'b1;
      n = -1; bc = 0; ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         n++;
         if (busy4) bc++;
         if (done4) begin ok = 1'b1; break; end
      end
   endtask

   task automatic drop_all();
      @(negedge clk);
      s1 = 1'b0; s4 = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      s1 = 0; m1 = 0; c1 = 0; a1 = 0; b1 = 0;
      s4 = 0; m4 = 0; c4 = 0; a4 = 0; b4 = 0;
      #1;
      vecs++;
      if ({busy1, done1, co1, ov1, sum1} !== 36'd0) begin
         errs++;
         $display("FAIL reset_d1 got %b%b%b%b %h want 0000 0",
                  busy1, done1, co1, ov1, sum1);
      end
      vecs++;
      if ({busy4, done4, co4, ov4, sum4} !== 36'd0) begin
         errs++;
         $display("FAIL reset_d4 got %b%b%b%b %h want 0000 0",
                  busy4, done4, co4, ov4, sum4);
      end
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_add_d1();
      logic ok; int n, bc;
      go1(32'hFFFF_FFFF, 32'h1, 1'b0, ok, n, bc);
      vecs++;
      if (!ok || n !== 33) begin
         errs++;
         $display("FAIL add_d1_latency ok=%b edge=%0d want 33", ok, n);
      end
      vecs++;
      if (bc !== 33) begin
         errs++;
         $display("FAIL add_d1_busy got %0d want 33", bc);
      end
      vecs++;
      if (sum1 !== 32'h0 || co1 !== 1'b1 || ov1 !== 1'b0) begin
         errs++;
         $display("FAIL add_d1_result got %h c%b v%b want 0 c1 v0",
                  sum1, co1, ov1);
      end
      drop_all();
   endtask

   task automatic test_sub_d1();
      logic ok; int n, bc;
      go1(32'd5, 32'd7, 1'b1, ok, n, bc);
      vecs++;
      if (!ok || sum1 !== 32'hFFFF_FFFE || co1 !== 1'b0 || ov1 !== 1'b0) begin
         errs++;
         $display("FAIL sub_5_7 ok=%b got %h c%b v%b want fffffffe c0 v0",
                  ok, sum1, co1, ov1);
      end
      drop_all();
      go1(32'd7, 32'd5, 1'b1, ok, n, bc);
      vecs++;
      if (!ok || sum1 !== 32'd2 || co1 !== 1'b1 || ov1 !== 1'b0) begin
         errs++;
         $display("FAIL sub_7_5 ok=%b got %h c%b v%b want 2 c1 v0",
                  ok, sum1, co1, ov1);
      end
      drop_all();
   endtask

   task automatic test_d4();
      logic ok; int n, bc;
      go4(32'h7FFF_FFFF, 32'h1, 1'b0, ok, n, bc);
      vecs++;
      if (!ok || n !== 9 || bc !== 9) begin
         errs++;
         $display("FAIL d4_latency ok=%b edge=%0d busy=%0d want 9 9",
                  ok, n, bc);
      end
      vecs++;
      if (sum4 !== 32'h8000_0000 || co4 !== 1'b0 || ov4 !== 1'b1) begin
         errs++;
         $display("FAIL d4_add_ovf got %h c%b v%b want 80000000 c0 v1",
                  sum4, co4, ov4);
      end
      drop_all();
      go4(32'h8000_0000, 32'h1, 1'b1, ok, n, bc);
      vecs++;
      if (!ok || sum4 !== 32'h7FFF_FFFF || co4 !== 1'b1 || ov4 !== 1'b1) begin
         errs++;
         $display("FAIL d4_sub_ovf ok=%b got %h c%b v%b want 7fffffff c1 v1",
                  ok, sum4, co4, ov4);
      end
      drop_all();
   endtask

   task automatic test_handshake();
      logic ok; int n, bc;
      go1(32'd3, 32'd4, 1'b0, ok, n, bc);
      a1 = 32'hDEAD_BEEF; b1 = 32'h1234_5678; m1 = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         vecs++;
         if (!ok || done1 !== 1'b1 || busy1 !== 1'b0 || sum1 !== 32'd7) begin
            errs++;
            $display("FAIL hold_done cyc=%0d done=%b busy=%b sum=%h want 1 0 7",
                     i, done1, busy1, sum1);
         end
      end
      drop_all();
      vecs++;
      if (done1 !== 1'b0 || busy1 !== 1'b0) begin
         errs++;
         $display("FAIL drop_idle done=%b busy=%b want 0 0", done1, busy1);
      end
      go1(32'd100, 32'd23, 1'b1, ok, n, bc);
      vecs++;
      if (!ok || sum1 !== 32'd77 || co1 !== 1'b1 || ov1 !== 1'b0) begin
         errs++;
         $display("FAIL retrigger ok=%b got %h c%b v%b want 4d c1 v0",
                  ok, sum1, co1, ov1);
      end
      drop_all();
   endtask

   task automatic test_rst_mid();
      logic ok; int n, bc;
      logic seen;
      @(negedge clk);
      a1 = 32'hFFFF_FFFF; b1 = 32'hFFFF_FFFF; m1 = 1'b0; s1 = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         if (busy1) begin seen = 1'b1; break; end
      end
      repeat (13) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      #1;
      vecs++;
      if (!seen || {busy1, done1, co1, ov1, sum1} !== 36'd0) begin
         errs++;
         $display("FAIL rst_mid seen=%b got %b%b%b%b %h want 0000 0",
                  seen, busy1, done1, co1, ov1, sum1);
      end
      s1 = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      go1(32'h1234_5678, 32'h1111_1111, 1'b0, ok, n, bc);
      vecs++;
      if (!ok || n !== 33 || sum1 !== 32'h2345_6789 || co1 !== 1'b0) begin
         errs++;
         $display("FAIL after_rst ok=%b edge=%0d got %h c%b want 33 23456789 c0",
                  ok, n, sum1, co1);
      end
      drop_all();
   endtask

   task automatic test_clear();
      int dn;
      @(negedge clk);
      s1 = 1'b1; c1 = 1'b1;
      @(posedge clk); #1;
      vecs++;
      if (busy1 !== 1'b0 || done1 !== 1'b0) begin
         errs++;
         $display("FAIL clear_idle busy=%b done=%b want 0 0", busy1, done1);
      end
      @(negedge clk);
      s1 = 1'b0; c1 = 1'b0;
      a1 = 32'hFFFF_FFFF; b1 = 32'hFFFF_FFFF; m1 = 1'b0;
      @(negedge clk);
      s1 = 1'b1;
      repeat (8) @(posedge clk);
      @(negedge clk);
      c1 = 1'b1; s1 = 1'b0;
      @(posedge clk); #1;
      vecs++;
      if (busy1 !== 1'b0 || done1 !== 1'b0 || sum1 !== 32'h0) begin
         errs++;
         $display("FAIL clear_mid busy=%b done=%b sum=%h want 0 0 0",
                  busy1, done1, sum1);
      end
      @(negedge clk);
      c1 = 1'b0;
      dn = 0;
      for (int i = 0; i < 40; i++) begin
         @(posedge clk); #1;
         if (done1 || busy1) dn++;
      end
      vecs++;
      if (dn !== 0) begin
         errs++;
         $display("FAIL clear_no_done active_cycles=%0d want 0", dn);
      end
   endtask

   initial begin
      test_reset();
      test_add_d1();
      test_sub_d1();
      test_d4();
      test_handshake();
      test_rst_mid();
      test_clear();
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
